// File: rtl/ascon_core_arbiter_pkg.sv
// Shared types and widths for the Ascon core arbiter and its helpers.
// Holds the arbiter state encoding and the saturating block-count helper.
package ascon_core_arbiter_pkg;

   localparam int KEY_W   = 128;
   localparam int NONCE_W = 128;
   localparam int DATA_W  = 64;
   localparam int TAG_W   = 128;
   localparam int BLK_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_DONE   = 3'd3,
      ST_ABORT  = 3'd4
   } arb_state_e;

   // Block counter sticks at all-ones so a runaway core cannot wrap it back to N_BLOCKS.
   function automatic logic [BLK_W-1:0] blk_sat_inc(input logic [BLK_W-1:0] v);
      logic [BLK_W-1:0] r;
      if (v == {BLK_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + BLK_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/ascon_core_arbiter_if.sv
// Bus between the arbiter (master) and the shared Ascon core (slave).
interface ascon_core_arbiter_if;
   import ascon_core_arbiter_pkg::*;

   logic                 core_resetb_o;
   logic                 core_start_o;
   logic                 core_data_valid_o;
   logic [DATA_W-1:0]    core_data_o;
   logic [KEY_W-1:0]     core_key_o;
   logic [NONCE_W-1:0]   core_nonce_o;
   logic                 core_cipher_valid_i;
   logic                 core_end_i;
   logic [DATA_W-1:0]    core_cipher_i;
   logic [TAG_W-1:0]     core_tag_i;

   modport master (
      output core_resetb_o, core_start_o, core_data_valid_o, core_data_o,
             core_key_o, core_nonce_o,
      input  core_cipher_valid_i, core_end_i, core_cipher_i, core_tag_i
   );

   modport slave (
      input  core_resetb_o, core_start_o, core_data_valid_o, core_data_o,
             core_key_o, core_nonce_o,
      output core_cipher_valid_i, core_end_i, core_cipher_i, core_tag_i
   );

endinterface

// File: rtl/ascon_core_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);

   // Scan from the pointer; the found flag keeps the earliest hit.
   always_comb begin
      logic        found_s;
      logic [PW-1:0] cand_s;
      gnt     = '0;
      idx     = '0;
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand_s = PW'((int'(ptr) + i) % N);
         if (!found_s && req[cand_s]) begin
            found_s     = 1'b1;
            gnt[cand_s] = 1'b1;
            idx         = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/ascon_core_arbiter.sv
// Round-robin owner of one Ascon core: latches key/nonce per grant, routes data,
// cipher and tag, and resets the core when its watchdog expires.
module ascon_core_arbiter
   import ascon_core_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int N_BLOCKS = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*KEY_W-1:0] key_i,
   input  logic [NUM_REQ*NONCE_W-1:0] nonce_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   input  logic [NUM_REQ-1:0]       data_valid_i,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic [NUM_REQ-1:0]       cipher_valid_o,
   output logic [DATA_W-1:0]        cipher_o,
   output logic [TAG_W-1:0]         tag_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic [NUM_REQ-1:0]       err_o,
   ascon_core_arbiter_if.master     core_if
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   arb_state_e          state_r, state_s;
   logic [NUM_REQ-1:0]  grant_r, grant_s;
   logic [PTR_W-1:0]    gidx_r, gidx_s;
   logic [PTR_W-1:0]    ptr_r, ptr_s;
   logic [KEY_W-1:0]    key_r, key_s;
   logic [NONCE_W-1:0]  nonce_r, nonce_s;
   logic [TAG_W-1:0]    tag_r, tag_s;
   logic [WD_W-1:0]     wd_r, wd_s;
   logic [BLK_W-1:0]    blk_r, blk_s;
   logic                abort_last_r, abort_last_s;
   logic [NUM_REQ-1:0]  pick_gnt_s;
   logic [PTR_W-1:0]    pick_idx_s;
   logic [PTR_W-1:0]    ptr_after_s;

   rr_picker #(.N(NUM_REQ), .PW(PTR_W)) u_picker (
      .req (req_i),
      .ptr (ptr_r),
      .gnt (pick_gnt_s),
      .idx (pick_idx_s)
   );

   assign ptr_after_s = (gidx_r == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_r + PTR_W'(1);

   // State register and all per-transaction context.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_r      <= ST_IDLE;
         grant_r      <= '0;
         gidx_r       <= '0;
         ptr_r        <= '0;
         key_r        <= '0;
         nonce_r      <= '0;
         tag_r        <= '0;
         wd_r         <= '0;
         blk_r        <= '0;
         abort_last_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         gidx_r       <= gidx_s;
         ptr_r        <= ptr_s;
         key_r        <= key_s;
         nonce_r      <= nonce_s;
         tag_r        <= tag_s;
         wd_r         <= wd_s;
         blk_r        <= blk_s;
         abort_last_r <= abort_last_s;
      end
   end

   // Next-state logic; end-of-run has priority over watchdog expiry.
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      gidx_s       = gidx_r;
      ptr_s        = ptr_r;
      key_s        = key_r;
      nonce_s      = nonce_r;
      tag_s        = tag_r;
      wd_s         = wd_r;
      blk_s        = blk_r;
      abort_last_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req_i) begin
               state_s = ST_LAUNCH;
               grant_s = pick_gnt_s;
               gidx_s  = pick_idx_s;
               key_s   = key_i[int'(pick_idx_s)*KEY_W +: KEY_W];
               nonce_s = nonce_i[int'(pick_idx_s)*NONCE_W +: NONCE_W];
            end else begin
               grant_s = '0;
            end
         end
         ST_LAUNCH: begin
            wd_s    = '0;
            blk_s   = '0;
            state_s = ST_RUN;
         end
         ST_RUN: begin
            wd_s = wd_r + WD_W'(1);
            if (core_if.core_cipher_valid_i) begin
               blk_s = blk_sat_inc(blk_r);
            end else begin
               blk_s = blk_r;
            end
            if (core_if.core_end_i) begin
               tag_s   = core_if.core_tag_i;
               state_s = ST_DONE;
            end else if (wd_s == WD_W'(TIMEOUT)) begin
               state_s = ST_ABORT;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            ptr_s   = ptr_after_s;
            grant_s = '0;
            state_s = ST_IDLE;
         end
         ST_ABORT: begin
            if (!abort_last_r) begin
               abort_last_s = 1'b1;
            end else begin
               ptr_s   = ptr_after_s;
               grant_s = '0;
               state_s = ST_IDLE;
            end
         end
         default: begin
            grant_s = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // Client/core routing and status pulses, decoded from the registered state.
   always_comb begin
      cipher_valid_o            = '0;
      core_if.core_data_valid_o = 1'b0;
      core_if.core_data_o       = '0;
      done_o                    = '0;
      err_o                     = '0;
      if (state_r == ST_RUN) begin
         core_if.core_data_o       = data_i[int'(gidx_r)*DATA_W +: DATA_W];
         core_if.core_data_valid_o = data_valid_i[gidx_r];
         if (core_if.core_cipher_valid_i) begin
            cipher_valid_o = grant_r;
         end else begin
            cipher_valid_o = '0;
         end
      end else if (state_r == ST_DONE) begin
         done_o = grant_r;
         if (blk_r != BLK_W'(N_BLOCKS)) begin
            err_o = grant_r;
         end else begin
            err_o = '0;
         end
      end else if ((state_r == ST_ABORT) && !abort_last_r) begin
         err_o = grant_r;
      end else begin
         done_o = '0;
      end
   end

   assign grant_o               = grant_r;
   assign cipher_o              = core_if.core_cipher_i;
   assign tag_o                 = tag_r;
   assign core_if.core_key_o    = key_r;
   assign core_if.core_nonce_o  = nonce_r;
   assign core_if.core_start_o  = (state_r == ST_LAUNCH);
   assign core_if.core_resetb_o = !(reset_i || (state_r == ST_ABORT));

endmodule
